// File: rtl/aes_dec_block_feeder.sv
// Packs a 32-bit ciphertext word stream into 128-bit blocks, buffers them and
// issues them to the AES-256 decipher pipeline on a fixed start_conversion grid.
module aes_dec_block_feeder #(
    parameter int ISSUE_INTERVAL = 8,
    parameter int BUF_DEPTH      = 2,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      in_word,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    input  logic             pipe_ready,
    input  logic             done_conversion,
    output logic [127:0]     cipher_text,
    output logic             start_conversion,
    output logic             last_conversion,
    output logic             busy,
    output logic [CNT_W-1:0] block_count,
    output logic             underrun
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam int SC_W  = (ISSUE_INTERVAL > 1) ? $clog2(ISSUE_INTERVAL) : 1;

    localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(BUF_DEPTH);
    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(ISSUE_INTERVAL - 1);
    localparam logic [SC_W-1:0]  SC_FIRST = (ISSUE_INTERVAL > 1) ? SC_W'(1) : '0;

    typedef enum logic [1:0] {IDLE, ISSUE, LAST_HOLD} state_t;

    state_t                        state;
    logic [SC_W-1:0]               sc;
    logic [BUF_DEPTH-1:0][127:0]   buf_data;
    logic [BUF_DEPTH-1:0]          buf_last;
    logic [PTR_W-1:0]              wr_ptr, rd_ptr;
    logic [OCC_W-1:0]              occ;
    logic [127:0]                  pack_data;
    logic [1:0]                    pack_idx;
    logic [127:0]                  blk;
    logic                          accept, push, pop;
    logic [127:0]                  head_data;
    logic                          head_last;

    assign in_ready  = !reset && (occ < DEPTH_C);
    assign accept    = in_valid && in_ready;
    assign push      = accept && (pack_idx == 2'd3 || in_last);
    assign head_data = buf_data[rd_ptr];
    assign head_last = buf_last[rd_ptr];
    assign busy      = (state != IDLE);

    // The IDLE->ISSUE transition cycle is itself slot 0, so the first block
    // goes out on that edge instead of waiting one more cycle.
    assign pop = (occ != '0) &&
                 ((state == IDLE && pipe_ready) || (state == ISSUE && sc == '0));

    // Unfilled slots of pack_data are always zero, giving the short-block padding.
    always_comb begin
        blk = pack_data;
        case (pack_idx)
            2'd0:    blk[127:96] = in_word;
            2'd1:    blk[95:64]  = in_word;
            2'd2:    blk[63:32]  = in_word;
            default: blk[31:0]   = in_word;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_data  <= '0;
            buf_last  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            pack_data <= '0;
            pack_idx  <= '0;
        end else begin
            if (accept) begin
                if (push) begin
                    buf_data[wr_ptr] <= blk;
                    buf_last[wr_ptr] <= in_last;
                    wr_ptr           <= wr_ptr + 1'b1;
                    pack_data        <= '0;
                    pack_idx         <= '0;
                end else begin
                    pack_data <= blk;
                    pack_idx  <= pack_idx + 1'b1;
                end
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            sc               <= '0;
            cipher_text      <= '0;
            start_conversion <= 1'b0;
            last_conversion  <= 1'b0;
            block_count      <= '0;
            underrun         <= 1'b0;
        end else begin
            start_conversion <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        cipher_text      <= head_data;
                        start_conversion <= 1'b1;
                        block_count      <= CNT_W'(1);
                        last_conversion  <= head_last;
                        sc               <= SC_FIRST;
                        state            <= head_last ? LAST_HOLD : ISSUE;
                    end
                end
                ISSUE: begin
                    sc <= (sc == SC_LAST) ? '0 : sc + 1'b1;
                    if (sc == '0) begin
                        if (occ != '0) begin
                            cipher_text      <= head_data;
                            start_conversion <= 1'b1;
                            block_count      <= block_count + 1'b1;
                            if (head_last) begin
                                last_conversion <= 1'b1;
                                state           <= LAST_HOLD;
                            end
                        end else begin
                            underrun <= 1'b1;
                        end
                    end
                end
                LAST_HOLD: begin
                    if (done_conversion) begin
                        last_conversion <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
